// File: rtl/pwm_modulator.sv
// rtl/pwm_modulator.sv - complementary PWM pair with double-buffered duty and dead time
module pwm_modulator #(
  parameter int PERIOD   = 64,
  parameter int DEADTIME = 2,
  parameter int PRESC_W  = 8
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [6:0]         duty_in,
  output logic               pwm_hi,
  output logic               pwm_lo,
  output logic               period_start,
  output logic [6:0]         duty_latched
);

  localparam int PW      = $clog2(PERIOD);
  localparam int DW      = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam int DT_LAST = (DEADTIME > 0) ? DEADTIME - 1 : 0;
  localparam logic [7:0] PERIOD8 = 8'(PERIOD);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HI_ON   = 3'd1,
    DEAD_HL = 3'd2,
    LO_ON   = 3'd3,
    DEAD_LH = 3'd4
  } state_t;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic [6:0]         duty_q, duty_d;
  logic               ps_q, ps_d;
  logic [DW-1:0]      dead_q, dead_d;
  state_t             state_q, state_d;

  logic       tick;
  logic       raw;
  logic       start;
  logic [6:0] duty_clamp;

  // Anything at or above full scale saturates to 100% duty; compare on 8 bits.
  assign duty_clamp = ({1'b0, duty_in} >= PERIOD8) ? PERIOD8[6:0] : duty_in;
  assign raw        = (8'(pcnt_q) < {1'b0, duty_q});
  assign start      = enable && (state_q == IDLE);
  assign tick       = (presc_q == prescale);

  // Prescaler, period counter and duty shadow register; duty reloads only at a boundary.
  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    duty_d  = duty_q;
    ps_d    = 1'b0;
    if (!enable) begin
      presc_d = '0;
      pcnt_d  = '0;
    end else if (start) begin
      presc_d = '0;
      pcnt_d  = '0;
      duty_d  = duty_clamp;
      ps_d    = 1'b1;
    end else if (tick) begin
      presc_d = '0;
      if (pcnt_q == PW'(PERIOD - 1)) begin
        pcnt_d = '0;
        duty_d = duty_clamp;
        ps_d   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Dead-time FSM: a switchover always passes through a full DEADTIME both-low window.
  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = (duty_clamp != 7'd0) ? HI_ON : LO_ON;
      end
      HI_ON: begin
        if (!raw) begin
          if (DEADTIME == 0) begin
            state_d = LO_ON;
          end else begin
            state_d = DEAD_HL;
            dead_d  = '0;
          end
        end
      end
      LO_ON: begin
        if (raw) begin
          if (DEADTIME == 0) begin
            state_d = HI_ON;
          end else begin
            state_d = DEAD_LH;
            dead_d  = '0;
          end
        end
      end
      DEAD_HL, DEAD_LH: begin
        if (dead_q == DW'(DT_LAST)) state_d = raw ? HI_ON : LO_ON;
        else dead_d = dead_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // State register; reset dominates everything including an active pulse.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
      duty_q  <= '0;
      ps_q    <= 1'b0;
      dead_q  <= '0;
      state_q <= IDLE;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      duty_q  <= duty_d;
      ps_q    <= ps_d;
      dead_q  <= dead_d;
      state_q <= state_d;
    end
  end

  assign pwm_hi       = (state_q == HI_ON);
  assign pwm_lo       = (state_q == LO_ON);
  assign period_start = ps_q;
  assign duty_latched = duty_q;

endmodule

// File: tb/tb_pwm_modulator.sv
// tb/tb_pwm_modulator.sv - randomized model-checked bench for pwm_modulator
module tb_pwm_modulator;
  localparam int PERIOD = 64;
  localparam int DT     = 2;
  localparam int S_IDLE = 0, S_HI = 1, S_LO = 2, S_GAP = 3;

  logic       sysclk = 1'b0;
  logic       reset, enable;
  logic [7:0] prescale;
  logic [6:0] duty_in;
  logic       pwm_hi, pwm_lo, period_start;
  logic [6:0] duty_latched;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  int m_presc = 0, m_pcnt = 0, m_duty = 0, m_ps = 0, m_side = S_IDLE, m_gap_left = 0;
  int last_drive = 0, gap = 0;

  always #5 sysclk = ~sysclk;

  pwm_modulator #(.PERIOD(PERIOD), .DEADTIME(DT), .PRESC_W(8)) dut (
    .sysclk(sysclk), .reset(reset), .enable(enable), .prescale(prescale),
    .duty_in(duty_in), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
    .period_start(period_start), .duty_latched(duty_latched)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: drive side and gap countdown evolve per cycle from the plain rules.
  always @(posedge sysclk) begin : model
    int cl;
    bit rw;
    cl = (int'(duty_in) >= PERIOD) ? PERIOD : int'(duty_in);
    if (reset) begin
      m_presc = 0; m_pcnt = 0; m_duty = 0; m_ps = 0; m_side = S_IDLE; m_gap_left = 0;
    end else if (!enable) begin
      m_presc = 0; m_pcnt = 0; m_ps = 0; m_side = S_IDLE;
    end else if (m_side == S_IDLE) begin
      m_duty = cl; m_pcnt = 0; m_presc = 0; m_ps = 1;
      m_side = (cl > 0) ? S_HI : S_LO;
    end else begin
      rw = (m_pcnt < m_duty);
      if (m_side == S_GAP) begin
        if (m_gap_left == 1) m_side = rw ? S_HI : S_LO;
        else m_gap_left--;
      end else if ((m_side == S_HI && !rw) || (m_side == S_LO && rw)) begin
        m_side = S_GAP; m_gap_left = DT;
      end
      if (m_presc == int'(prescale)) begin
        m_presc = 0;
        if (m_pcnt == PERIOD - 1) begin
          m_pcnt = 0; m_ps = 1; m_duty = cl;
        end else begin
          m_pcnt++; m_ps = 0;
        end
      end else begin
        m_presc = (m_presc + 1) % 256; m_ps = 0;
      end
    end
  end

  // Per-cycle comparison against the model plus overlap and dead-gap invariants.
  always @(negedge sysclk) begin
    if (chk_en) begin
      chk("pwm_hi", pwm_hi, m_side == S_HI);
      chk("pwm_lo", pwm_lo, m_side == S_LO);
      chk("period_start", period_start, m_ps);
      chk("duty_latched", duty_latched, m_duty);
      chk("hi_and_lo", pwm_hi & pwm_lo, 0);
      if (m_side == S_IDLE) begin
        last_drive = 0; gap = 0;
      end else if (pwm_hi | pwm_lo) begin
        if (last_drive != 0 && (pwm_hi ? 1 : 2) != last_drive) chk("dead_gap_min", gap >= DT, 1);
        last_drive = pwm_hi ? 1 : 2;
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  task automatic wait_ps(input string nm);
    int n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!period_start && n < 1000);
    chk({nm, "_ps_seen"}, period_start, 1);
  endtask

  task automatic count(input int len, output int hi, output int lo);
    hi = 0; lo = 0;
    for (int i = 0; i < len; i++) begin
      hi += pwm_hi; lo += pwm_lo;
      @(negedge sysclk);
    end
  endtask

  initial begin
    int hi, lo;
    reset = 1'b1; enable = 1'b0; prescale = 8'd0; duty_in = 7'd0;
    repeat (3) @(negedge sysclk);
    chk_en = 1;
    chk("rst_hi", pwm_hi, 0);
    chk("rst_lo", pwm_lo, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_duty", duty_latched, 0);

    reset = 1'b0; enable = 1'b1; duty_in = 7'd16;
    @(negedge sysclk);
    chk("start_ps", period_start, 1);
    chk("start_hi", pwm_hi, 1);
    wait_ps("t1a");
    count(64, hi, lo);
    chk("t1_hi", hi, 14);
    chk("t1_lo", lo, 46);
    chk("t1_both_low", 64 - hi - lo, 4);
    chk("t1_period64", period_start, 1);

    duty_in = 7'd0;
    wait_ps("t2a");
    chk("t2_duty0", duty_latched, 0);
    count(64, hi, lo);
    chk("t2_hi0", hi, 0);
    chk("t2_lo64", lo, 64);
    duty_in = 7'd127;
    wait_ps("t2b");
    chk("t2_clamp", duty_latched, 64);
    wait_ps("t2c");
    count(64, hi, lo);
    chk("t2_hi64", hi, 64);
    chk("t2_lo_full", lo, 0);

    duty_in = 7'd16;
    wait_ps("t3a");
    wait_ps("t3b");
    repeat (20) @(negedge sysclk);
    duty_in = 7'd40;
    @(negedge sysclk);
    chk("t3_hold16", duty_latched, 16);
    wait_ps("t3c");
    chk("t3_new40", duty_latched, 40);
    count(64, hi, lo);
    chk("t3_hi", hi, 38);
    chk("t3_lo", lo, 22);

    prescale = 8'd3;
    wait_ps("t4a");
    count(256, hi, lo);
    chk("t4_period256", period_start, 1);
    chk("t4_hi", hi, 158);
    chk("t4_lo", lo, 94);
    prescale = 8'd0;

    duty_in = 7'd127;
    wait_ps("t5a");
    wait_ps("t5b");
    repeat (5) @(negedge sysclk);
    chk("t5_hi_before", pwm_hi, 1);
    reset = 1'b1;
    @(negedge sysclk);
    chk("t5_rst_hi", pwm_hi, 0);
    chk("t5_rst_lo", pwm_lo, 0);
    reset = 1'b0;
    @(negedge sysclk);
    chk("t5_restart_ps", period_start, 1);
    chk("t5_restart_hi", pwm_hi, 1);
    repeat (5) @(negedge sysclk);
    enable = 1'b0;
    @(negedge sysclk);
    chk("t5_dis_hi", pwm_hi, 0);
    chk("t5_dis_ps", period_start, 0);
    enable = 1'b1;
    @(negedge sysclk);
    chk("t5_reen_ps", period_start, 1);
    chk("t5_reen_hi", pwm_hi, 1);

    for (int i = 0; i < 10000; i++) begin
      duty_in = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 999) == 0) prescale = 8'($urandom_range(0, 2));
      enable = ($urandom_range(0, 499) != 0);
      reset  = ($urandom_range(0, 2999) == 0);
      @(negedge sysclk);
    end
    reset = 1'b0; enable = 1'b1;
    @(negedge sysclk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
